// File: rtl/mux4_way16_rr_if.sv
// Bundle of the four source channels, their valid/ready handshakes and the merged output stream.
// The mux sits on the slave side; whatever feeds and drains it uses the master side.
interface mux4_way16_rr_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       valid;
    logic [3:0]       ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       sel;

    modport master (
        output a, b, c, d, valid, out_ready,
        input  ready, out, out_valid, sel
    );

    modport slave (
        input  a, b, c, d, valid, out_ready,
        output ready, out, out_valid, sel
    );
endinterface

// File: rtl/mux4_way16_rr.sv
// Four-channel round-robin merge into a single registered output slot.
// Define MUX4_WAY16_RR_COUNT_EN to add a 16-bit wrapping count of output handshakes.
module mux4_way16_rr #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mux4_way16_rr_if.slave       bus
`ifdef MUX4_WAY16_RR_COUNT_EN
    ,
    output logic [15:0]          count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [WIDTH-1:0] outReg;
    logic [1:0]       selReg;

    logic             loadOk;
    logic             grantFound;
    logic [1:0]       grantIdx;
    logic [1:0]       scanIdx;
    logic [WIDTH-1:0] grantData;
    logic             doLoad;

    // Search for the first requesting channel starting at ptr and wrapping past d back to a.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = ptr;
        scanIdx    = ptr;
        for (int k = 0; k < 4; k++) begin
            scanIdx = ptr + 2'(k);
            if (!grantFound && bus.valid[scanIdx]) begin
                grantFound = 1'b1;
                grantIdx   = scanIdx;
            end
        end
    end

    always_comb begin
        grantData = bus.a;
        case (grantIdx)
            2'd0:    grantData = bus.a;
            2'd1:    grantData = bus.b;
            2'd2:    grantData = bus.c;
            default: grantData = bus.d;
        endcase
    end

    assign loadOk = (state == EMPTY) || bus.out_ready;
    assign doLoad = loadOk && grantFound && !reset;

    assign bus.ready     = doLoad ? (4'b0001 << grantIdx) : 4'b0000;
    assign bus.out       = outReg;
    assign bus.sel       = selReg;
    assign bus.out_valid = (state == FULL);

    // A full slot being drained may be refilled in the same cycle, so a load takes priority over emptying.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            ptr    <= 2'd0;
            outReg <= '0;
            selReg <= 2'd0;
        end else if (doLoad) begin
            state  <= FULL;
            outReg <= grantData;
            selReg <= grantIdx;
            ptr    <= grantIdx + 2'd1;
        end else if (state == FULL && bus.out_ready) begin
            state <= EMPTY;
        end
    end

`ifdef MUX4_WAY16_RR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 16'd0;
        end else if (state == FULL && bus.out_ready) begin
            count <= count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux4_way16_rr.sv
// Directed bench for mux4_way16_rr: a vector table of single-cycle steps plus hand-written stall and counter sequences.
// Inputs change on the falling edge; ready is sampled before the rising edge, registered outputs just after it.
module tb_mux4_way16_rr;

    localparam int WIDTH = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mux4_way16_rr_if #(.WIDTH(WIDTH)) bus ();

`ifdef MUX4_WAY16_RR_COUNT_EN
    logic [15:0] count;
    mux4_way16_rr #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus), .count(count));
`else
    mux4_way16_rr #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  valid;
        logic        outReady;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] d;
        logic [3:0]  expReady;
        logic [15:0] expOut;
        logic [1:0]  expSel;
        logic        expValid;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset         = v.rst;
        bus.valid     = v.valid;
        bus.out_ready = v.outReady;
        bus.a         = v.a;
        bus.b         = v.b;
        bus.c         = v.c;
        bus.d         = v.d;
        #1;
        checkOutput({v.name, ".ready"}, 32'(bus.ready), 32'(v.expReady));
        @(posedge clk);
        #1;
        checkOutput({v.name, ".out"}, 32'(bus.out), 32'(v.expOut));
        checkOutput({v.name, ".sel"}, 32'(bus.sel), 32'(v.expSel));
        checkOutput({v.name, ".out_valid"}, 32'(bus.out_valid), 32'(v.expValid));
    endtask

    // Round-robin scoreboard for the stall sequence: every channel requests, out_ready toggles.
    task automatic stallSequence();
        logic [15:0] data [4];
        logic [7:0]  pattern;
        logic [1:0]  mPtr;
        logic        mFull;
        logic [15:0] mOut;
        logic [1:0]  mSel;
        logic        mLoad;
        data[0] = 16'hA000; data[1] = 16'hA001; data[2] = 16'hA002; data[3] = 16'hA003;
        pattern = 8'b1011_0010;
        mPtr = 2'd0; mFull = 1'b0; mOut = 16'h4444; mSel = 2'd3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reset = 1'b0;
            bus.valid = 4'b1111;
            bus.a = data[0]; bus.b = data[1]; bus.c = data[2]; bus.d = data[3];
            bus.out_ready = pattern[i];
            mLoad = !mFull || pattern[i];
            #1;
            checkOutput($sformatf("stall%0d.ready", i), 32'(bus.ready), mLoad ? 32'(4'b0001 << mPtr) : 32'd0);
            if (mLoad) begin
                mOut  = data[mPtr];
                mSel  = mPtr;
                mFull = 1'b1;
                mPtr  = mPtr + 2'd1;
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall%0d.out", i), 32'(bus.out), 32'(mOut));
            checkOutput($sformatf("stall%0d.sel", i), 32'(bus.sel), 32'(mSel));
            checkOutput($sformatf("stall%0d.out_valid", i), 32'(bus.out_valid), 32'(mFull));
        end
    endtask

`ifdef MUX4_WAY16_RR_COUNT_EN
    // 65537 handshakes wrap the counter once and leave it at 1.
    task automatic countSequence();
        @(negedge clk);
        reset = 1'b1;
        bus.valid = 4'b1111;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("count.reset", 32'(count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 65538; i++) @(posedge clk);
        #1;
        checkOutput("count.wrap", 32'(count), 32'd1);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.valid = 4'b0000;
        bus.out_ready = 1'b0;
        bus.a = 16'h1111; bus.b = 16'h2222; bus.c = 16'h3333; bus.d = 16'h4444;

        //           name        rst  valid     ordy  a         b         c         d         ready     out       sel   ov
        vecs.push_back('{"reset",   1'b1, 4'b1111, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0000, 16'h0000, 2'd0, 1'b0});
        vecs.push_back('{"rr0",     1'b0, 4'b1111, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0001, 16'h1111, 2'd0, 1'b1});
        vecs.push_back('{"rr1",     1'b0, 4'b1111, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0010, 16'h2222, 2'd1, 1'b1});
        vecs.push_back('{"rr2",     1'b0, 4'b1111, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0100, 16'h3333, 2'd2, 1'b1});
        vecs.push_back('{"rr3",     1'b0, 4'b1111, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b1000, 16'h4444, 2'd3, 1'b1});
        vecs.push_back('{"rrwrap",  1'b0, 4'b1111, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0001, 16'h1111, 2'd0, 1'b1});
        vecs.push_back('{"drain",   1'b0, 4'b0000, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0000, 16'h1111, 2'd0, 1'b0});
        vecs.push_back('{"idle",    1'b0, 4'b0000, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0000, 16'h1111, 2'd0, 1'b0});
        vecs.push_back('{"loadC",   1'b0, 4'b0100, 1'b0, 16'h1111, 16'h2222, 16'hBEEF, 16'h4444, 4'b0100, 16'hBEEF, 2'd2, 1'b1});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{$sformatf("hold%0d", i), 1'b0, 4'b0100, 1'b0, 16'h1111, 16'h2222, 16'hBEEF, 16'h4444, 4'b0000, 16'hBEEF, 2'd2, 1'b1});
        vecs.push_back('{"fromD",   1'b0, 4'b1111, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b1000, 16'h4444, 2'd3, 1'b1});
        vecs.push_back('{"bStall",  1'b0, 4'b0010, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0000, 16'h4444, 2'd3, 1'b1});
        vecs.push_back('{"bDrop",   1'b0, 4'b0100, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0100, 16'h3333, 2'd2, 1'b1});
        vecs.push_back('{"loadAA",  1'b0, 4'b0001, 1'b1, 16'h00AA, 16'h2222, 16'h3333, 16'h4444, 4'b0001, 16'h00AA, 2'd0, 1'b1});
        vecs.push_back('{"midRst",  1'b1, 4'b1000, 1'b0, 16'h00AA, 16'h2222, 16'h3333, 16'h4444, 4'b0000, 16'h0000, 2'd0, 1'b0});
        vecs.push_back('{"postRst", 1'b0, 4'b1001, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0001, 16'h1111, 2'd0, 1'b1});
        vecs.push_back('{"onlyD",   1'b0, 4'b1000, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b1000, 16'h4444, 2'd3, 1'b1});
        vecs.push_back('{"lastDrn", 1'b0, 4'b0000, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0000, 16'h4444, 2'd3, 1'b0});

        $display("[TB] applying %0d table vectors", vecs.size());
        foreach (vecs[i]) applyStimulus(vecs[i]);

        stallSequence();

`ifdef MUX4_WAY16_RR_COUNT_EN
        countSequence();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
